// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use stall detection and stall counter
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Valid_i,
  input  logic              ALUSrc_i,
  input  logic              ResultSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [9:0]        Funct_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic              Flush_i,
  output logic              Valid_o,
  output logic              ALUSrc_o,
  output logic              ResultSrc_o,
  output logic              RegWrite_o,
  output logic              MemWrite_o,
  output logic              Branch_o,
  output logic [1:0]        ALUOp_o,
  output logic [9:0]        Funct_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [ADDR_W-1:0] RS1addr_o,
  output logic [ADDR_W-1:0] RS2addr_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic              Stall_o,
  output logic [CNT_W-1:0]  StallCnt_o
);

  logic ex_load;
  logic use_rs1;
  logic use_rs2;
  logic hazard;

  // rs2 only matters for R-type, branches and stores; I-type ALU ops read the immediate instead
  assign ex_load = Valid_o & RegWrite_o & ResultSrc_o & (RDaddr_o != '0);
  assign use_rs1 = Valid_i;
  assign use_rs2 = Valid_i & (~ALUSrc_i | MemWrite_i);
  assign hazard  = ex_load & ((use_rs1 & (RS1addr_i == RDaddr_o)) |
                              (use_rs2 & (RS2addr_i == RDaddr_o)));
  assign Stall_o = hazard & ~Flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Valid_o     <= 1'b0;
      ALUSrc_o    <= 1'b0;
      ResultSrc_o <= 1'b0;
      RegWrite_o  <= 1'b0;
      MemWrite_o  <= 1'b0;
      Branch_o    <= 1'b0;
      ALUOp_o     <= 2'b00;
      Funct_o     <= '0;
      RS1data_o   <= '0;
      RS2data_o   <= '0;
      Imm_o       <= '0;
      RS1addr_o   <= '0;
      RS2addr_o   <= '0;
      RDaddr_o    <= '0;
      StallCnt_o  <= '0;
    end else begin
      if (Flush_i | Stall_o) begin
        Valid_o     <= 1'b0;
        ALUSrc_o    <= 1'b0;
        ResultSrc_o <= 1'b0;
        RegWrite_o  <= 1'b0;
        MemWrite_o  <= 1'b0;
        Branch_o    <= 1'b0;
        ALUOp_o     <= 2'b00;
        Funct_o     <= '0;
        RS1data_o   <= '0;
        RS2data_o   <= '0;
        Imm_o       <= '0;
        RS1addr_o   <= '0;
        RS2addr_o   <= '0;
        RDaddr_o    <= '0;
      end else begin
        Valid_o     <= Valid_i;
        ALUSrc_o    <= ALUSrc_i;
        // ResultSrc is undefined from the decoder when nothing is written back
        ResultSrc_o <= ResultSrc_i & RegWrite_i & Valid_i;
        RegWrite_o  <= RegWrite_i & Valid_i;
        MemWrite_o  <= MemWrite_i & Valid_i;
        Branch_o    <= Branch_i & Valid_i;
        ALUOp_o     <= ALUOp_i;
        Funct_o     <= Funct_i;
        RS1data_o   <= RS1data_i;
        RS2data_o   <= RS2data_i;
        Imm_o       <= Imm_i;
        RS1addr_o   <= RS1addr_i;
        RS2addr_o   <= RS2addr_i;
        RDaddr_o    <= RDaddr_i;
      end
      if (Stall_o && (StallCnt_o != {CNT_W{1'b1}}))
        StallCnt_o <= StallCnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register with load-use hazard detection, placed directly downstream of the instruction decoder's control-signal generator. Each cycle it captures the decoded control bits (ALUSrc, ResultSrc, RegWrite, ALUOp, MemWrite, Branch), register-file read data, the immediate and the register indices for the EX stage. It detects a load-use dependency between the instruction in EX and the one in ID, then raises a stall and inserts a bubble. It also counts inserted stall cycles.

## Interface
- DATA_W, 32, width of register data and immediate
- ADDR_W, 5, width of register indices
- CNT_W, 16, width of stall counter

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- Valid_i  in  1  ID-stage instruction is valid
- ALUSrc_i, ResultSrc_i, RegWrite_i, MemWrite_i, Branch_i  in  1 each  decoder control bits
- ALUOp_i  in  2  decoder ALU op class
- Funct_i  in  10  {funct7, funct3} of ID instruction
- RS1data_i, RS2data_i, Imm_i  in  DATA_W each  register read data, sign-extended immediate
- RS1addr_i, RS2addr_i, RDaddr_i  in  ADDR_W each  register indices
- Flush_i  in  1  squash ID instruction (branch taken downstream)
- Valid_o, ALUSrc_o, ResultSrc_o, RegWrite_o, MemWrite_o, Branch_o  out  1 each  registered EX copies
- ALUOp_o  out  2;  Funct_o  out  10;  RS1data_o, RS2data_o, Imm_o  out  DATA_W;  RS1addr_o, RS2addr_o, RDaddr_o  out  ADDR_W  registered EX copies
- Stall_o  out  1  combinational; hold PC and IF/ID register this cycle
- StallCnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- EX is a load when Valid_o & RegWrite_o & ResultSrc_o & (RDaddr_o != 0).
- ID uses rs1 when Valid_i. ID uses rs2 when Valid_i & (~ALUSrc_i | MemWrite_i), which covers R-type, beq and sw.
- Hazard = EX is a load & ((uses rs1 & RS1addr_i == RDaddr_o) | (uses rs2 & RS2addr_i == RDaddr_o)).
- Stall_o = hazard & ~Flush_i.
- Register update each rising edge, in priority order:
  1. Flush_i or Stall_o: load a bubble. Valid_o, RegWrite_o, MemWrite_o, Branch_o, ResultSrc_o and ALUSrc_o go to 0; ALUOp_o goes to 00. Data, address and Funct outputs load 0.
  2. Otherwise: load all inputs. Valid_o takes Valid_i. Control bits are gated so that RegWrite_o, MemWrite_o and Branch_o equal input & Valid_i.
- ResultSrc_o stores ResultSrc_i & RegWrite_i & Valid_i. The decoder drives X on ResultSrc for sw/beq, and this gating stops that X from reaching EX.
- StallCnt_o increments by 1 on each edge where Stall_o=1. It saturates at all-ones and never wraps.
- There are no other states. The block is a single register bank plus a counter.

## Timing
- Latency: ID inputs appear on the EX outputs 1 cycle after the edge that samples them.
- Stall_o is a same-cycle function of the current EX outputs and the ID inputs. There is no registered delay.
- A load followed by a dependent instruction gives exactly one stall cycle. On the next cycle EX holds the bubble, so the hazard clears and the held ID instruction advances.
- If Flush_i and a hazard occur in the same cycle, the flush wins: Stall_o=0, a bubble is loaded and the counter is unchanged.
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - All registered outputs are 0, ALUOp_o is 00 and StallCnt_o is 0.
  - Stall_o is 0 while reset is held, because Valid_o=0.
- After reset deasserts, the first edge loads normally.
- RDaddr_o=0 never produces a hazard.

## Test plan
- Reset mid-stream: assert rst_i between edges. All outputs go to 0 immediately and StallCnt_o=0. Deassert, then present addi x5 (Valid_i=1, ALUSrc_i=1, RegWrite_i=1, RDaddr_i=5, Imm_i=7). Next edge: RegWrite_o=1, RDaddr_o=5, Imm_o=7, Stall_o=0.
- Load-use on rs1: lw x3 in EX, then add with RS1addr_i=3. Stall_o=1 for exactly 1 cycle and a bubble lands in EX (Valid_o=0). The add enters EX on the following edge and StallCnt_o=1.
- rs2 qualification: lw x4 in EX, ID addi with RS2addr_i=4 (ALUSrc_i=1, MemWrite_i=0) gives Stall_o=0. The same with sw (MemWrite_i=1) gives Stall_o=1.
- x0 and non-load cases:
  - lw x0 in EX, ID RS1addr_i=0: Stall_o=0.
  - add x3 in EX (ResultSrc_o=0), ID RS1addr_i=3: Stall_o=0.
  - sw in EX with ResultSrc_i=X: ResultSrc_o=0 and Stall_o=0.
- Flush vs stall: load-use hazard with Flush_i=1 in the same cycle gives Stall_o=0, a bubble loaded, StallCnt_o unchanged, and no X on any output.
- Counter saturation (CNT_W=2): force 5 stall cycles. StallCnt_o reads 1, 2, 3, 3, 3.
